seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
- Transmit-side counterpart of the serial "1001" sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a single-bit line `x`, one bit per clock, for direct connection to the detector's `x` input.
- Keeps a reference model of the overlapping "1001" Moore detector on its own output stream. It produces the expected detector output `exp_match` and a running match count, so the pair can be self-checked in system.

Parameters:
WIDTH, 8, bits per loaded word (legal 4..32)
CNT_W, 8, width of match_cnt (legal 2..16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load_data is valid
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to serialize, MSB sent first
clr_cnt  input  1  synchronous clear of match_cnt
x  output  1  serial bit stream to detector; 0 whenever not shifting
x_valid  output  1  x carries a data bit this cycle
done  output  1  one-cycle pulse after the last bit of a word
exp_match  output  1  expected Moore detector output for the stream on x
match_cnt  output  CNT_W  saturating count of exp_match pulses

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; shift register and bit counter=0; x=0, x_valid=0, done=0, exp_match=0, match_cnt=0, 4-bit history=0. load_ready=1 is a combinational function of state.
- Handshake: a transfer occurs in cycle t when load_valid and load_ready are both 1 at the rising edge ending cycle t.
- load_ready=1 in IDLE, and in SHIFT only during the last-bit cycle (bit_cnt==0). It is 0 otherwise.
- FSM states: IDLE, SHIFT.
  - IDLE --transfer--> SHIFT.
  - SHIFT, bit_cnt>0: shift left one bit, decrement bit_cnt.
  - SHIFT, bit_cnt==0 with transfer: reload, stay in SHIFT. Back-to-back words have no gap.
  - SHIFT, bit_cnt==0 without transfer: go to IDLE.
- Timing for a transfer in cycle t:
  - Cycle t+1+i, i=0..WIDTH-1: x=load_data[WIDTH-1-i] and x_valid=1.
  - Cycle t+WIDTH+1: done=1, whether or not a new word starts that cycle.
- x and x_valid are registered outputs. Outside SHIFT, x=0 and x_valid=0.
- Reference model:
  - hist[3:0] <= {hist[2:0], x} on every clock, including idle cycles, because the detector samples x every clock.
  - exp_match <= (hist[2:0]==3'b100) && (x==1).
  - Result: exp_match=1 in cycle n+1 iff x in cycles n-3..n was 1,0,0,1. This matches the detector's Moore output timing, including overlap: "1001001" gives two matches.
- match_cnt update on each edge:
  - clr_cnt=1: clear to 0. Clear has priority over increment.
  - Otherwise, when the exp_match-set condition is true and match_cnt is not all-ones: increment by 1.
  - At all-ones, match_cnt holds (saturates).
- load_data is ignored when no transfer occurs. load_valid held high while load_ready=0 does not affect the current word.
- A reset asserted mid-word aborts the word immediately; no done pulse is produced.

Test Plan:
- Reset, then release with load_valid=0 -> x=0, x_valid=0, done=0, exp_match=0, match_cnt=0, load_ready=1 for ≥10 cycles.
- Load 8'h99 in cycle t -> x=1,0,0,1,1,0,0,1 in cycles t+1..t+8; x_valid=1 in exactly those cycles; exp_match=1 only in t+5 and t+9; done=1 in t+9; match_cnt=2.
- Load 8'h92, then 8'h48 in its last-bit cycle -> 16 contiguous bits with no gap (x_valid stays 1); done at t+9 and t+17; overlapping matches give match_cnt=4.
- Load 8'h01, idle so that x=0 for exactly two cycles (t+9, t+10), then load 8'h80 in cycle t+10 -> cross-word-boundary match, exp_match=1 in cycle t+12, match_cnt=1.
- CNT_W=2: send 8'h99 twice back-to-back (4 matches) -> match_cnt saturates at 3. Assert clr_cnt in the same cycle as a match -> match_cnt=0.
- Assert reset in the 3rd bit cycle of 8'hFF -> x=0, x_valid=0 and match_cnt=0 immediately (asynchronous); after release, load_ready=1 and no done pulse.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serializes parallel words MSB-first onto x and tracks what an overlapping "1001"
// Moore detector watching x should report, including a saturating match count.
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_cnt,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             exp_match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BCW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic [3:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_set;

  // The shift register is zeroed whenever the FSM leaves SHIFT, so its MSB is x directly.
  assign x          = shift_q[WIDTH-1];
  assign x_valid    = (state_q == SHIFT);
  assign done       = done_q;
  assign load_ready = (state_q == IDLE) || (bit_cnt_q == '0);
  assign match_cnt  = cnt_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d   = SHIFT;
          shift_d   = load_data;
          bit_cnt_d = BCW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - BCW'(1);
        end else begin
          done_d = 1'b1;
          if (load_valid) begin
            shift_d   = load_data;
            bit_cnt_d = BCW'(WIDTH - 1);
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // hist_q holds x from the previous four cycles, newest in bit 0; the detector samples every clock.
  assign match_set = (hist_q[2:0] == 3'b100) && x;
  assign exp_match = (hist_q == 4'b1001);

  always_comb begin
    hist_d = {hist_q[2:0], x};
    cnt_d  = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match_set && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      hist_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
